// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} rf_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_NUM_RD = 3;
   localparam int DEF_PC_IDX = 15;

endpackage

// File: rtl/rf_read_port.sv
// One read port: zero/PC/bypass/array priority mux plus busy-flag lookup.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int PC_IDX      = DEF_PC_IDX,
   parameter int ZERO_REG_EN = 1
) (
   input  logic                           active,
   input  logic [ADDR_W-1:0]              addr,
   input  logic                           wr_en,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic [DATA_W-1:0]              pc_val,
   input  logic [(2**ADDR_W)*DATA_W-1:0]  regs,
   input  logic [(2**ADDR_W)-1:0]         busy_vec,
   output logic [DATA_W-1:0]              data,
   output logic                           busy
);

   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   // Nothing leaks out while the clear engine owns the array.
   always_comb begin
      data = '0;
      if (active) begin
         if (ZERO_REG_EN != 0 && addr == '0)
            data = '0;
         else if (addr == PC_A)
            data = pc_val;
         else if (wr_en && wr_addr == addr)
            data = wr_data;
         else
            data = regs[int'(addr)*DATA_W +: DATA_W];
      end
   end

   assign busy = active ? busy_vec[addr] : 1'b0;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with clear engine, PC alias and busy scoreboard.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int NUM_RD      = DEF_NUM_RD,
   parameter int PC_IDX      = DEF_PC_IDX,
   parameter int ZERO_REG_EN = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [DATA_W-1:0]          pc_val,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       sb_set_en,
   input  logic [ADDR_W-1:0]          sb_set_addr,
   input  logic                       clear_req,
   output logic                       ready,
   output rf_state_t                  fsm_state
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS-1);
   // Indices whose busy flag is hard-wired to zero.
   localparam logic [NUM_REGS-1:0] FIXED =
      (NUM_REGS'(1) << PC_IDX) | ((ZERO_REG_EN != 0) ? NUM_REGS'(1) : '0);

   rf_state_t               state;
   logic [ADDR_W-1:0]       clr_cnt;
   logic                    ready_q;
   logic [NUM_REGS-1:0]     busy;
   logic [NUM_REGS*DATA_W-1:0] mem;
   logic                    wr_ok;
   logic                    is_ready;

   assign is_ready  = (state == READY);
   assign ready     = ready_q;
   assign fsm_state = state;
   assign wr_ok     = !(ZERO_REG_EN != 0 && wr_addr == '0) && (wr_addr != PC_A);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready_q <= 1'b0;
         busy    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_A) begin
                  state   <= READY;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               if (clear_req) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
                  ready_q <= 1'b0;
                  busy    <= '0;
               end else begin
                  // A newly issued producer supersedes a completing write.
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (!FIXED[i] && sb_set_en && sb_set_addr == ADDR_W'(i))
                        busy[i] <= 1'b1;
                     else if (wr_en && wr_addr == ADDR_W'(i))
                        busy[i] <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; the clear engine is the only way it gets zeroed.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[int'(clr_cnt)*DATA_W +: DATA_W] <= '0;
      else if (wr_en && !clear_req && wr_ok)
         mem[int'(wr_addr)*DATA_W +: DATA_W] <= wr_data;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      rf_read_port #(
         .DATA_W      (DATA_W),
         .ADDR_W      (ADDR_W),
         .PC_IDX      (PC_IDX),
         .ZERO_REG_EN (ZERO_REG_EN)
      ) u_port (
         .active   (is_ready),
         .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .pc_val   (pc_val),
         .regs     (mem),
         .busy_vec (busy),
         .data     (rd_data[k*DATA_W +: DATA_W]),
         .busy     (rd_busy[k])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: clear timing, bypass, special indices, scoreboard, clear/reset restarts.
module tb_reg_file_mp;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pc_val;
   logic [11:0] rd_addr;
   logic [95:0] rd_data;
   logic [2:0]  rd_busy;
   logic        sb_set_en;
   logic [3:0]  sb_set_addr;
   logic        clear_req;
   logic        ready;
   rf_state_t   fsm_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cnt;
   logic [95:0] exp_rd;

   reg_file_mp dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pc_val(pc_val), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clear_req(clear_req),
      .ready(ready), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      rd_addr = {a2, a1, a0};
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Counts rising edges until ready goes high, bounded.
   task automatic wait_ready(output int edges);
      edges = 0;
      while (!ready && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc_val = '0;
      rd_addr = '0; sb_set_en = 1'b0; sb_set_addr = '0; clear_req = 1'b0;

      // Reset then idle
      repeat (3) @(negedge clk);
      set_rd(4'd15, 4'd15, 4'd15);
      pc_val = 32'h0000_0108;
      #1;
      check("reset_ready", 96'(ready), 96'd0);
      check("reset_state", 96'(fsm_state), 96'(CLEAR));
      check("reset_rd_data", rd_data, 96'd0);
      check("reset_rd_busy", 96'(rd_busy), 96'd0);
      rst = 1'b1;
      pc_val = '0;
      wait_ready(cnt);
      check("clear_len_after_reset", 96'(cnt), 96'd16);
      check("ready_state", 96'(fsm_state), 96'(READY));
      for (int i = 0; i < 16; i++) begin
         set_rd(4'(i), 4'(i), 4'(i)); #1;
         check("idle_read_zero", rd_data, 96'd0);
      end

      // Write and bypass
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
      set_rd(4'd3, 4'd0, 4'd1); #1;
      check("bypass_same_cycle", 96'(rd_data[31:0]), 96'h0000_0000_0000_0000_DEAD_BEEF);
      check("bypass_other_ports", rd_data[95:32], 96'd0);
      @(negedge clk);
      wr_en = 1'b0; #1;
      check("read_after_write", 96'(rd_data[31:0]), 96'h0000_0000_0000_0000_DEAD_BEEF);

      // Special indices
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234;
      set_rd(4'd0, 4'd0, 4'd0); #1;
      check("zero_no_bypass", rd_data, 96'd0);
      @(negedge clk);
      wr_addr = 4'd15;
      @(negedge clk);
      wr_en = 1'b0; pc_val = 32'h0000_0108;
      set_rd(4'd0, 4'd0, 4'd0); #1;
      check("zero_reg_reads_0", rd_data, 96'd0);
      set_rd(4'd15, 4'd15, 4'd15); #1;
      check("pc_alias_all_ports", rd_data, {32'h108, 32'h108, 32'h108});

      // Scoreboard
      @(negedge clk);
      sb_set_en = 1'b1; sb_set_addr = 4'd5;
      set_rd(4'd5, 4'd5, 4'd5); #1;
      check("busy_before_edge", 96'(rd_busy), 96'd0);
      @(negedge clk);
      sb_set_en = 1'b0; #1;
      check("busy_set", 96'(rd_busy), 96'b111);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55; #1;
      check("busy_not_bypassed", 96'(rd_busy), 96'b111);
      @(negedge clk);
      wr_en = 1'b0; #1;
      check("busy_cleared_by_write", 96'(rd_busy), 96'd0);
      check("reg5_value", rd_data, {32'h55, 32'h55, 32'h55});
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h66;
      sb_set_en = 1'b1; sb_set_addr = 4'd5;
      @(negedge clk);
      wr_en = 1'b0; sb_set_en = 1'b0; #1;
      check("set_wins_over_clear", 96'(rd_busy), 96'b111);
      @(negedge clk);
      sb_set_en = 1'b1; sb_set_addr = 4'd15;
      @(negedge clk);
      sb_set_en = 1'b0;
      set_rd(4'd15, 4'd15, 4'd15); #1;
      check("pc_busy_const0", 96'(rd_busy), 96'd0);

      // Clear request
      for (int i = 1; i < 15; i++) write_reg(4'(i), 32'h1000_0000 + 32'(i));
      @(negedge clk);
      sb_set_en = 1'b1; sb_set_addr = 4'd7;
      @(negedge clk);
      sb_set_en = 1'b0;
      set_rd(4'd9, 4'd7, 4'd14); #1;
      check("regs_loaded", rd_data, {32'h1000_000E, 32'h1000_0007, 32'h1000_0009});
      check("reg7_busy", 96'(rd_busy), 96'b010);
      @(negedge clk);
      clear_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hAAAA_AAAA;
      @(negedge clk);
      clear_req = 1'b0; wr_en = 1'b0;
      set_rd(4'd7, 4'd2, 4'd15); #1;
      check("clear_ready_low", 96'(ready), 96'd0);
      check("clear_reads_zero", rd_data, 96'd0);
      check("clear_busy_zero", 96'(rd_busy), 96'd0);
      cnt = 0;
      while (!ready && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 4) begin
            wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h77;
            sb_set_en = 1'b1; sb_set_addr = 4'd1;
         end
         if (cnt == 8) begin
            wr_en = 1'b0; sb_set_en = 1'b0;
         end
      end
      check("clear_len_after_req", 96'(cnt + 1), 96'd17);
      for (int i = 0; i < 16; i++) begin
         set_rd(4'(i), 4'(i), 4'(i)); #1;
         exp_rd = (i == 15) ? {32'h108, 32'h108, 32'h108} : 96'd0;
         check("after_clear_read", rd_data, exp_rd);
      end
      set_rd(4'd7, 4'd1, 4'd2); #1;
      check("after_clear_busy", 96'(rd_busy), 96'd0);

      // Reset mid-clear
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0; #1;
      check("midclear_rst_ready", 96'(ready), 96'd0);
      @(negedge clk);
      rst = 1'b1;
      wait_ready(cnt);
      check("clear_len_after_midrst", 96'(cnt), 96'd16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
